// File: rtl/issue_scoreboard_if.sv
// Purpose: issue/candidate/hazard signal bundle between the issue stage and the scoreboard.
// Latency: n/a (wires only).
// Backpressure: Stall/HazardE/HazardO are the backpressure toward the issue stage.
// Ports: master = issue stage (drives issue + candidate fields, sees hazards);
//        slave  = scoreboard (consumes issue + candidate fields, drives hazards/status).
interface issue_scoreboard_if;
  logic        Flush;
  logic        IssueE, IssueO;
  logic        WrE, WrO;
  logic [6:0]  RTE, RTO;
  logic [3:0]  LatE, LatO;
  logic [2:0]  CandUseE, CandUseO;
  logic [6:0]  CandRAE, CandRBE, CandRCE, CandRTE;
  logic [6:0]  CandRAO, CandRBO, CandRCO, CandRTO;
  logic        CandWrE, CandWrO;
  logic        HazardE, HazardO, Stall;
  logic        Idle;
  logic [15:0] StallCycles;

  modport master (
    output Flush, IssueE, IssueO, WrE, WrO, RTE, RTO, LatE, LatO,
           CandUseE, CandUseO, CandRAE, CandRBE, CandRCE, CandRTE,
           CandRAO, CandRBO, CandRCO, CandRTO, CandWrE, CandWrO,
    input  HazardE, HazardO, Stall, Idle, StallCycles
  );

  modport slave (
    input  Flush, IssueE, IssueO, WrE, WrO, RTE, RTO, LatE, LatO,
           CandUseE, CandUseO, CandRAE, CandRBE, CandRCE, CandRTE,
           CandRAO, CandRBO, CandRCO, CandRTO, CandWrE, CandWrO,
    output HazardE, HazardO, Stall, Idle, StallCycles
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Purpose: dual-pipe register scoreboard; per-register 4-bit result countdown, RAW/WAW hazard detect.
// Latency: hazards are combinational on registered counts; issues become visible one cycle later.
// Backpressure: Stall = HazardE | HazardO is raised toward the issue stage; nothing is dropped.
// Ports: clk, rst_n (sync, active-low); sb (slave modport) carries issue, candidate and status signals.
module issue_scoreboard (
  input  logic               clk,
  input  logic               rst_n,
  issue_scoreboard_if.slave  sb
);

  logic [3:0]   cnt     [128];
  logic [3:0]   cnt_nxt [128];
  logic [127:0] busy;
  logic         acc_e, acc_o;
  logic         haz_e, haz_o;
  logic         idle_q;
  logic [15:0]  stall_cnt;

  // Zero latency or a non-writing issue has nothing to track.
  assign acc_e = sb.IssueE & sb.WrE & ~sb.Flush & (sb.LatE != 4'd0);
  assign acc_o = sb.IssueO & sb.WrO & ~sb.Flush & (sb.LatO != 4'd0);

  always_comb begin
    for (int r = 0; r < 128; r++) begin
      busy[r] = (cnt[r] != 4'd0);
    end
  end

  // Next count: decrement-saturate, then an accepted issue keeps the larger of
  // its latency and the remaining count, so an older, longer write is never hidden.
  always_comb begin
    for (int r = 0; r < 128; r++) begin
      cnt_nxt[r] = busy[r] ? cnt[r] - 4'd1 : 4'd0;
      if (acc_e && (sb.RTE == 7'(r)) && (sb.LatE > cnt_nxt[r])) cnt_nxt[r] = sb.LatE;
      if (acc_o && (sb.RTO == 7'(r)) && (sb.LatO > cnt_nxt[r])) cnt_nxt[r] = sb.LatO;
    end
  end

  // Use mask is {RA,RB,RC}; WAW check against the candidate's own destination.
  assign haz_e = (sb.CandUseE[2] & busy[sb.CandRAE]) |
                 (sb.CandUseE[1] & busy[sb.CandRBE]) |
                 (sb.CandUseE[0] & busy[sb.CandRCE]) |
                 (sb.CandWrE     & busy[sb.CandRTE]);
  assign haz_o = (sb.CandUseO[2] & busy[sb.CandRAO]) |
                 (sb.CandUseO[1] & busy[sb.CandRBO]) |
                 (sb.CandUseO[0] & busy[sb.CandRCO]) |
                 (sb.CandWrO     & busy[sb.CandRTO]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 128; r++) cnt[r] <= 4'd0;
      idle_q    <= 1'b1;
      stall_cnt <= 16'd0;
    end else begin
      for (int r = 0; r < 128; r++) cnt[r] <= cnt_nxt[r];
      // Idle lags the counts by a cycle: it reflects the counts seen this cycle.
      idle_q <= ~|busy;
      if ((haz_e | haz_o) && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign sb.HazardE     = haz_e;
  assign sb.HazardO     = haz_o;
  assign sb.Stall       = haz_e | haz_o;
  assign sb.Idle        = idle_q;
  assign sb.StallCycles = stall_cnt;

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   failures  = 0;
  bit   exp_q[$];

  issue_scoreboard_if sb();

  issue_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sb.Flush = 0; sb.IssueE = 0; sb.IssueO = 0; sb.WrE = 0; sb.WrO = 0;
    sb.RTE = 0; sb.RTO = 0; sb.LatE = 0; sb.LatO = 0;
    sb.CandUseE = 0; sb.CandUseO = 0;
    sb.CandRAE = 0; sb.CandRBE = 0; sb.CandRCE = 0; sb.CandRTE = 0;
    sb.CandRAO = 0; sb.CandRBO = 0; sb.CandRCO = 0; sb.CandRTO = 0;
    sb.CandWrE = 0; sb.CandWrO = 0;
  endtask

  task automatic clear_issue();
    sb.IssueE = 0; sb.IssueO = 0; sb.WrE = 0; sb.WrO = 0; sb.LatE = 0; sb.LatO = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic issue_e(input logic [6:0] rt, input logic [3:0] lat);
    sb.IssueE = 1; sb.WrE = 1; sb.RTE = rt; sb.LatE = lat;
  endtask

  task automatic issue_o(input logic [6:0] rt, input logic [3:0] lat);
    sb.IssueO = 1; sb.WrO = 1; sb.RTO = rt; sb.LatO = lat;
  endtask

  task automatic push_run(input int ones);
    for (int i = 0; i < ones; i++) exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sb.CandUseE = 3'($urandom_range(7)); sb.CandUseO = 3'($urandom_range(7));
      sb.CandRAE = 7'($urandom); sb.CandRBE = 7'($urandom); sb.CandRCE = 7'($urandom);
      sb.CandRTE = 7'($urandom); sb.CandRAO = 7'($urandom); sb.CandRBO = 7'($urandom);
      sb.CandRCO = 7'($urandom); sb.CandRTO = 7'($urandom);
      sb.CandWrE = 1; sb.CandWrO = 1;
      @(negedge clk);
      tests_run++;
      if ({sb.HazardE, sb.HazardO, sb.Stall} !== 3'b000) begin
        failures++;
        $display("FAIL reset_hazard[%0d]: got %b expected 000", i, {sb.HazardE, sb.HazardO, sb.Stall});
      end
      step();
    end
    @(negedge clk);
    tests_run++;
    if (sb.Idle !== 1'b1) begin
      failures++; $display("FAIL reset_idle: got %b expected 1", sb.Idle);
    end
    tests_run++;
    if (sb.StallCycles !== 16'd0) begin
      failures++; $display("FAIL reset_stallcycles: got %0d expected 0", sb.StallCycles);
    end
  endtask

  // E writes r5 with latency 3; even candidate reads r5 as RA.
  task automatic test_raw();
    bit exp;
    int idx = 0;
    do_reset();
    issue_e(7'd5, 4'd3);
    step();
    clear_issue();
    sb.CandUseE = 3'b100; sb.CandRAE = 7'd5;
    push_run(3);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      @(negedge clk);
      tests_run++;
      if (sb.HazardE !== exp || sb.Stall !== exp) begin
        failures++;
        $display("FAIL raw_hazard[%0d]: got HazardE=%b Stall=%b expected %b", idx, sb.HazardE, sb.Stall, exp);
      end
      if (idx == 3) begin
        tests_run++;
        if (sb.Idle !== 1'b0) begin
          failures++; $display("FAIL raw_idle_lag: got %b expected 0", sb.Idle);
        end
      end
      idx++;
      step();
    end
    @(negedge clk);
    tests_run++;
    if (sb.StallCycles !== 16'd3) begin
      failures++; $display("FAIL raw_stallcycles: got %0d expected 3", sb.StallCycles);
    end
    tests_run++;
    if (sb.Idle !== 1'b1) begin
      failures++; $display("FAIL raw_idle_return: got %b expected 1", sb.Idle);
    end
  endtask

  // Both pipes write r9 together; odd candidate also writes r9 (WAW).
  task automatic test_dual_waw();
    bit exp;
    int idx = 0;
    do_reset();
    issue_e(7'd9, 4'd2);
    issue_o(7'd9, 4'd6);
    step();
    clear_issue();
    sb.CandWrO = 1; sb.CandRTO = 7'd9;
    push_run(6);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      @(negedge clk);
      tests_run++;
      if (sb.HazardO !== exp || sb.HazardE !== 1'b0) begin
        failures++;
        $display("FAIL dual_waw[%0d]: got HazardO=%b HazardE=%b expected %b/0", idx, sb.HazardO, sb.HazardE, exp);
      end
      idx++;
      step();
    end
    tests_run++;
    if (sb.StallCycles !== 16'd6) begin
      failures++; $display("FAIL dual_waw_stallcycles: got %0d expected 6", sb.StallCycles);
    end
  endtask

  // Reissue to a busy register keeps the larger remaining latency.
  task automatic test_reissue_max();
    bit exp;
    for (int pass = 0; pass < 2; pass++) begin
      int idx = 0;
      do_reset();
      issue_e(7'd12, 4'd4);
      step();
      issue_e(7'd12, 4'd2);
      step();
      if (pass == 1) begin
        issue_o(7'd12, 4'd7);
        sb.IssueE = 0;
        step();
      end
      clear_issue();
      sb.CandUseE = 3'b010; sb.CandRBE = 7'd12;
      push_run(pass == 0 ? 3 : 7);
      while (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        @(negedge clk);
        tests_run++;
        if (sb.HazardE !== exp) begin
          failures++;
          $display("FAIL reissue_max_p%0d[%0d]: got %b expected %b", pass, idx, sb.HazardE, exp);
        end
        idx++;
        step();
      end
    end
  endtask

  // Flushed, zero-latency and non-writing issues do not load; flush leaves counts running.
  task automatic test_flush();
    bit exp;
    int idx = 0;
    do_reset();
    sb.Flush = 1;
    issue_e(7'd20, 4'd5);
    step();
    clear_issue();
    sb.Flush = 0;
    sb.CandUseE = 3'b001; sb.CandRCE = 7'd20;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if (sb.HazardE !== 1'b0 || sb.Idle !== 1'b1) begin
        failures++;
        $display("FAIL flush_drop[%0d]: got HazardE=%b Idle=%b expected 0/1", i, sb.HazardE, sb.Idle);
      end
      step();
    end
    issue_o(7'd21, 4'd0);
    issue_e(7'd22, 4'd5);
    sb.WrE = 0;
    step();
    clear_issue();
    sb.CandUseO = 3'b100; sb.CandRAO = 7'd21;
    sb.CandUseE = 3'b100; sb.CandRAE = 7'd22;
    @(negedge clk);
    tests_run++;
    if (sb.HazardO !== 1'b0 || sb.HazardE !== 1'b0) begin
      failures++;
      $display("FAIL no_accept: got HazardO=%b HazardE=%b expected 0/0", sb.HazardO, sb.HazardE);
    end
    step();
    clear_inputs();
    issue_e(7'd20, 4'd3);
    step();
    clear_issue();
    sb.Flush = 1;
    sb.CandUseE = 3'b001; sb.CandRCE = 7'd20;
    push_run(3);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      @(negedge clk);
      tests_run++;
      if (sb.HazardE !== exp) begin
        failures++;
        $display("FAIL flush_keeps_cnt[%0d]: got %b expected %b", idx, sb.HazardE, exp);
      end
      idx++;
      step();
    end
    tests_run++;
    if (sb.StallCycles !== 16'd3) begin
      failures++; $display("FAIL flush_keeps_stallcycles: got %0d expected 3", sb.StallCycles);
    end
    sb.Flush = 0;
  endtask

  // Register 0 has no special case.
  task automatic test_reg0();
    bit exp;
    int idx = 0;
    do_reset();
    issue_o(7'd0, 4'd1);
    step();
    clear_issue();
    sb.CandUseO = 3'b001; sb.CandRCO = 7'd0;
    push_run(1);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      @(negedge clk);
      tests_run++;
      if (sb.HazardO !== exp) begin
        failures++;
        $display("FAIL reg0[%0d]: got %b expected %b", idx, sb.HazardO, exp);
      end
      idx++;
      step();
    end
  endtask

  // Reset mid-countdown, with a simultaneous issue that must be ignored.
  task automatic test_reset_mid();
    do_reset();
    issue_e(7'd3, 4'd15);
    step();
    clear_issue();
    sb.CandUseE = 3'b100; sb.CandRAE = 7'd3;
    repeat (4) step();
    @(negedge clk);
    tests_run++;
    if (sb.HazardE !== 1'b1) begin
      failures++; $display("FAIL reset_mid_busy: got %b expected 1", sb.HazardE);
    end
    step();
    rst_n = 0;
    issue_e(7'd3, 4'd15);
    issue_o(7'd3, 4'd15);
    step();
    rst_n = 1;
    clear_issue();
    @(negedge clk);
    tests_run++;
    if ({sb.HazardE, sb.Stall, sb.Idle} !== 3'b001 || sb.StallCycles !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_clear: got HazardE/Stall/Idle=%b StallCycles=%0d expected 001/0",
               {sb.HazardE, sb.Stall, sb.Idle}, sb.StallCycles);
    end
  endtask

  // Keep r1 busy by reissuing every cycle while the even candidate reads it.
  task automatic test_saturate();
    do_reset();
    issue_e(7'd1, 4'd15);
    step();
    sb.CandUseE = 3'b100; sb.CandRAE = 7'd1;
    @(negedge clk);
    tests_run++;
    if (sb.StallCycles !== 16'd0 || sb.Stall !== 1'b1) begin
      failures++;
      $display("FAIL sat_start: got StallCycles=%0d Stall=%b expected 0/1", sb.StallCycles, sb.Stall);
    end
    repeat (65534) step();
    @(negedge clk);
    tests_run++;
    if (sb.StallCycles !== 16'hFFFE) begin
      failures++; $display("FAIL sat_before: got %0d expected 65534", sb.StallCycles);
    end
    step();
    @(negedge clk);
    tests_run++;
    if (sb.StallCycles !== 16'hFFFF) begin
      failures++; $display("FAIL sat_reach: got %0d expected 65535", sb.StallCycles);
    end
    repeat (4500) step();
    @(negedge clk);
    tests_run++;
    if (sb.StallCycles !== 16'hFFFF) begin
      failures++; $display("FAIL sat_hold: got %0d expected 65535", sb.StallCycles);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_raw();
    test_dual_waw();
    test_reissue_max();
    test_flush();
    test_reg0();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
